// File: rtl/cram_arbiter.sv
// cram_arbiter: two-requester round-robin arbiter in front of a CellularRAM
// burst controller. A winner's address/data are latched and held, with CE,
// until the controller reports end of burst. A one-cycle RELEASE state then
// drops CE and pulses the owner's Done.
// Optional watchdog: define CRAM_ARB_TIMEOUT_EN to abort a BUSY phase after
// TIMEOUT_CYCLES cycles without CtlDone. With the macro undefined, BUSY waits
// indefinitely and Timeout is tied low.
module cram_arbiter #(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Data0,
  input  logic [DATA_W-1:0] Data1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Done0,
  output logic              Done1,
  output logic              CtlCE,
  output logic [ADDR_W-1:0] CtlAddress,
  output logic [DATA_W-1:0] CtlData,
  input  logic              CtlYield,
  input  logic              CtlDone,
  output logic              Timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  // A zero watchdog limit would make BUSY end before the controller can act.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cram_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_e              state_q, state_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic                ce_q, ce_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  // Requester that wins a tie; set to the non-owner whenever a transaction ends.
  logic                prio_q, prio_d;
  logic                win1;
  logic                finish;

`ifdef CRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                tmo_q, tmo_d;
  assign cnt_inc = cnt_q + CNT_W'(1);
`endif

  // Requester 1 wins when it is alone, or when both ask and it holds priority.
  assign win1 = Req1 & (~Req0 | prio_q);

  // Next-state and registered-output computation for IDLE/BUSY/RELEASE.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    ce_d    = ce_q;
    addr_d  = addr_q;
    data_d  = data_q;
    prio_d  = prio_q;
    finish  = 1'b0;
`ifdef CRAM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if ((Req0 | Req1) & CtlYield) begin
          state_d = S_BUSY;
          ce_d    = 1'b1;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          addr_d  = win1 ? Addr1 : Addr0;
          data_d  = win1 ? Data1 : Data0;
`ifdef CRAM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_BUSY: begin
        finish = CtlDone;
`ifdef CRAM_ARB_TIMEOUT_EN
        cnt_d = cnt_inc;
        // CtlDone on the limit cycle still counts as a normal completion.
        if (!CtlDone && (cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
          finish = 1'b1;
          tmo_d  = 1'b1;
        end
`endif
        if (finish) begin
          state_d = S_RELEASE;
          ce_d    = 1'b0;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          done0_d = gnt0_q;
          done1_d = gnt1_q;
          prio_d  = gnt0_q;
        end
      end

      S_RELEASE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        ce_d    = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      // NOTE: the latched address/data are reset too, so the controller never
      // sees stale values from before reset.
      state_q <= S_IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      ce_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      prio_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the
      // same pre-edge values.
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      ce_q    <= ce_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      prio_q  <= prio_d;
    end
  end

`ifdef CRAM_ARB_TIMEOUT_EN
  // Watchdog counter and abort pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign Timeout = tmo_q;
`else
  assign Timeout = 1'b0;
`endif

  assign Gnt0       = gnt0_q;
  assign Gnt1       = gnt1_q;
  assign Done0      = done0_q;
  assign Done1      = done1_q;
  assign CtlCE      = ce_q;
  assign CtlAddress = addr_q;
  assign CtlData    = data_q;

endmodule

// File: tb/tb_cram_arbiter.sv
// tb_cram_arbiter: directed bench for cram_arbiter. Inputs change 1 time unit
// after each rising edge; outputs are checked at that same point, reflecting
// the registers loaded on that edge.
module tb_cram_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int TMO    = 8;

  logic              CLK;
  logic              RST_N;
  logic              Req0, Req1;
  logic [ADDR_W-1:0] Addr0, Addr1;
  logic [DATA_W-1:0] Data0, Data1;
  logic              Gnt0, Gnt1, Done0, Done1, CtlCE;
  logic [ADDR_W-1:0] CtlAddress;
  logic [DATA_W-1:0] CtlData;
  logic              CtlYield, CtlDone, Timeout;

  int total = 0;
  int bad   = 0;

  cram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Req0(Req0), .Req1(Req1),
    .Addr0(Addr0), .Addr1(Addr1),
    .Data0(Data0), .Data1(Data1),
    .Gnt0(Gnt0), .Gnt1(Gnt1),
    .Done0(Done0), .Done1(Done1),
    .CtlCE(CtlCE), .CtlAddress(CtlAddress), .CtlData(CtlData),
    .CtlYield(CtlYield), .CtlDone(CtlDone), .Timeout(Timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Advance one cycle and confirm the mutual-exclusion invariants.
  task automatic tick_excl();
    tick();
    check("gnt_excl", 32'(Gnt0 & Gnt1), 32'd0);
    check("done_excl", 32'(Done0 & Done1), 32'd0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    Addr0 = '0; Addr1 = '0; Data0 = '0; Data1 = '0;
    CtlYield = 1'b1; CtlDone = 1'b0;

    // Reset state
    do_reset();
    check("rst_ce", 32'(CtlCE), 32'd0);
    check("rst_gnt", {30'd0, Gnt1, Gnt0}, 32'd0);
    check("rst_done", {30'd0, Done1, Done0}, 32'd0);
    check("rst_addr", 32'(CtlAddress), 32'd0);
    check("rst_data", 32'(CtlData), 32'd0);
    check("rst_tmo", 32'(Timeout), 32'd0);

    // Single transaction from requester 0
    Req0 = 1'b1; Addr0 = 20'h00010; Data0 = 16'hABCD;
    tick();
    check("t1_gnt0", 32'(Gnt0), 32'd1);
    check("t1_gnt1", 32'(Gnt1), 32'd0);
    check("t1_ce", 32'(CtlCE), 32'd1);
    check("t1_addr", 32'(CtlAddress), 32'h00010);
    check("t1_data", 32'(CtlData), 32'hABCD);
    Req0 = 1'b0;
    tick();
    tick();
    CtlDone = 1'b1;
    tick();
    CtlDone = 1'b0;
    check("t1_done0", 32'(Done0), 32'd1);
    check("t1_done1", 32'(Done1), 32'd0);
    check("t1_ce_rel", 32'(CtlCE), 32'd0);
    check("t1_gnt_rel", 32'(Gnt0), 32'd0);
    tick();
    check("t1_done_pulse", 32'(Done0), 32'd0);

    // Both requesting from a fresh reset: grants alternate 0,1,0,1
    do_reset();
    Addr0 = 20'h0AAAA; Data0 = 16'h0A0A; Addr1 = 20'h22222; Data1 = 16'h1111;
    Req0 = 1'b1; Req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_excl();
      check("rr_gnt0", 32'(Gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_gnt1", 32'(Gnt1), (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_addr", 32'(CtlAddress), (i % 2 == 0) ? 32'h0AAAA : 32'h22222);
      tick_excl();
      tick_excl();
      CtlDone = 1'b1;
      tick_excl();
      CtlDone = 1'b0;
      check("rr_done0", 32'(Done0), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_done1", 32'(Done1), (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_ce_low", 32'(CtlCE), 32'd0);
      tick_excl();
      check("rr_idle_ce", 32'(CtlCE), 32'd0);
    end
    Req0 = 1'b0; Req1 = 1'b0;
    tick();

    // Controller not yielding: nothing issued until CtlYield rises
    CtlYield = 1'b0; Req1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ny_ce", 32'(CtlCE), 32'd0);
      check("ny_gnt1", 32'(Gnt1), 32'd0);
    end
    CtlYield = 1'b1;
    tick();
    check("ny_gnt1_on", 32'(Gnt1), 32'd1);
    check("ny_addr", 32'(CtlAddress), 32'h22222);
    check("ny_data", 32'(CtlData), 32'h1111);
    Req1 = 1'b0;
    CtlDone = 1'b1;
    tick();
    CtlDone = 1'b0;
    check("ny_done1", 32'(Done1), 32'd1);
    tick();

    // BUSY ignores input changes; CtlDone outside BUSY is ignored
    Req0 = 1'b1; Addr0 = 20'h00123; Data0 = 16'h5A5A;
    tick();
    check("hold_gnt0", 32'(Gnt0), 32'd1);
    Req0 = 1'b0; Addr0 = 20'hFFFFF; Data0 = 16'h0000; Req1 = 1'b1;
    tick();
    Req1 = 1'b0;
    tick();
    check("hold_addr", 32'(CtlAddress), 32'h00123);
    check("hold_data", 32'(CtlData), 32'h5A5A);
    check("hold_gnt0_b", 32'(Gnt0), 32'd1);
    check("hold_gnt1", 32'(Gnt1), 32'd0);
    check("hold_ce", 32'(CtlCE), 32'd1);
    CtlDone = 1'b1;
    tick();
    check("hold_done0", 32'(Done0), 32'd1);
    tick();
    check("ign_done_rel", 32'(Done0), 32'd0);
    tick();
    check("ign_done_idle", {29'd0, CtlCE, Done1, Done0}, 32'd0);
    CtlDone = 1'b0;
    tick();

    // Reset during BUSY: CE and grant drop on that edge, no Done
    Req0 = 1'b1; Addr0 = 20'h00456;
    tick();
    check("rb_gnt0", 32'(Gnt0), 32'd1);
    Req0 = 1'b0;
    RST_N = 1'b0;
    tick();
    check("rb_ce", 32'(CtlCE), 32'd0);
    check("rb_gnt0_off", 32'(Gnt0), 32'd0);
    check("rb_done0", 32'(Done0), 32'd0);
    check("rb_addr", 32'(CtlAddress), 32'd0);
    RST_N = 1'b1;
    tick();
    check("rb_done0_after", 32'(Done0), 32'd0);
    check("rb_ce_after", 32'(CtlCE), 32'd0);

    // Watchdog behaviour
    Req0 = 1'b1; Addr0 = 20'h00789;
    tick();
    check("wd_gnt0", 32'(Gnt0), 32'd1);
    Req0 = 1'b0;
`ifdef CRAM_ARB_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      check("wd_busy", {30'd0, Timeout, CtlCE}, 32'd1);
    end
    tick();
    check("wd_tmo", 32'(Timeout), 32'd1);
    check("wd_done0", 32'(Done0), 32'd1);
    check("wd_ce", 32'(CtlCE), 32'd0);
    tick();
    check("wd_tmo_pulse", {30'd0, Timeout, Done0}, 32'd0);
    // CtlDone on the limit cycle is a normal completion
    Req0 = 1'b1;
    tick();
    check("wd2_gnt0", 32'(Gnt0), 32'd1);
    Req0 = 1'b0;
    for (int i = 0; i < TMO - 1; i++) tick();
    CtlDone = 1'b1;
    tick();
    CtlDone = 1'b0;
    check("wd2_done0", 32'(Done0), 32'd1);
    check("wd2_tmo", 32'(Timeout), 32'd0);
    tick();
`else
    for (int i = 0; i < 3 * TMO; i++) begin
      tick();
      check("nowd_busy", {29'd0, Timeout, Done0, CtlCE}, 32'd1);
    end
    check("nowd_gnt0", 32'(Gnt0), 32'd1);
    CtlDone = 1'b1;
    tick();
    CtlDone = 1'b0;
    check("nowd_done0", 32'(Done0), 32'd1);
    check("nowd_tmo", 32'(Timeout), 32'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cram_arbiter.md
CRAM_ARBITER -- requirements
Module: cram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 20, address width toward the CellularRAM burst controller.
REQ-002 SHALL have parameter DATA_W, 16, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 64, BUSY-cycle limit, used only when CRAM_ARB_TIMEOUT_EN is defined.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports Req0/Req1  input  1  requester n asks for one burst transaction.
REQ-007 SHALL have ports Addr0/Addr1  input  ADDR_W  start address from requester n.
REQ-008 SHALL have ports Data0/Data1  input  DATA_W  write data from requester n.
REQ-009 SHALL have ports Gnt0/Gnt1  output  1  requester n owns the controller.
REQ-010 SHALL have ports Done0/Done1  output  1  one-cycle pulse: requester n's transaction finished.
REQ-011 SHALL have port CtlCE  output  1  start/hold enable to the burst controller CE input.
REQ-012 SHALL have port CtlAddress  output  ADDR_W  latched address to the controller AddressIn.
REQ-013 SHALL have port CtlData  output  DATA_W  latched data to the controller DataIn.
REQ-014 SHALL have port CtlYield  input  1  controller idle and able to accept CE.
REQ-015 SHALL have port CtlDone  input  1  controller end-of-burst pulse.
REQ-016 SHALL have port Timeout  output  1  one-cycle pulse: transaction aborted by watchdog.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, RELEASE.
REQ-018 IDLE: when (Req0|Req1) & CtlYield at an edge, SHALL select a winner, latch its Addr/Data into CtlAddress/CtlData, assert its Gnt and CtlCE, enter BUSY; CtlCE visible the cycle after the request is sampled.
REQ-019 IDLE with CtlYield=0 SHALL issue nothing, regardless of requests.
REQ-020 Arbitration SHALL be round-robin: single requester wins; both requesting, the one not granted last wins; pointer after reset favours requester 0.
REQ-021 BUSY: CtlCE, Gnt and CtlAddress/CtlData SHALL hold constant; Req/Addr/Data changes ignored, including Req deasserting.
REQ-022 BUSY on CtlDone=1 SHALL enter RELEASE.
REQ-023 RELEASE (exactly one cycle): CtlCE=0, Gnt=0, Done of the owner=1, pointer updated to owner; next state IDLE.
REQ-024 Gnt0 and Gnt1 SHALL never both be 1; Done0 and Done1 SHALL never both be 1.
REQ-025 CtlCE SHALL be low for at least one cycle (RELEASE) between consecutive transactions.
REQ-026 CtlDone while in IDLE or RELEASE SHALL be ignored.
REQ-027 Request present during RELEASE SHALL be arbitrated in the following IDLE cycle, with the updated pointer.
REQ-028 Back-to-back single requester held high SHALL be granted every transaction (3-cycle minimum period given immediate CtlDone).

Reset
REQ-029 RST_N=0 at an edge SHALL force IDLE, pointer to favour 0, CtlCE=0, Gnt0=Gnt1=0, Done0=Done1=0, Timeout=0, CtlAddress=0, CtlData=0, watchdog count=0.
REQ-030 Reset mid-BUSY SHALL drop CtlCE on that same edge with no Done pulse.
REQ-031 After RST_N returns high, first arbitration SHALL occur no earlier than the next edge.

Configuration
REQ-032 Macro CRAM_ARB_TIMEOUT_EN defined: counter clears on BUSY entry, increments each BUSY cycle; reaching TIMEOUT_CYCLES without CtlDone SHALL enter RELEASE, pulse owner's Done and Timeout together.
REQ-033 CtlDone in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as normal completion (Timeout=0).
REQ-034 Macro undefined: no counter; BUSY waits indefinitely for CtlDone; Timeout tied 0; port list identical.

Verification
REQ-035 Reset, Req0=1 Addr0=0x00010 Data0=0xABCD, CtlYield=1 -> Gnt0 and CtlCE high next cycle, CtlAddress=0x00010, CtlData=0xABCD; CtlDone at cycle 5 -> Done0 pulse cycle 6, CtlCE low.
REQ-036 Req0=Req1=1 held, CtlDone 3 cycles after each CtlCE rise -> grants alternate 0,1,0,1; Gnt never overlap.
REQ-037 Req1=1 with CtlYield=0 for 10 cycles -> CtlCE, Gnt1 stay 0; CtlYield=1 -> Gnt1 next cycle.
REQ-038 Grant 0, then change Addr0 to 0xFFFFF and drop Req0 in BUSY -> CtlAddress unchanged, Done0 still pulses on CtlDone.
REQ-039 RST_N=0 during BUSY -> CtlCE, Gnt0 zero after that edge, no Done0 pulse.
REQ-040 CRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, CtlDone never -> Timeout and Done0 pulse after 8 BUSY cycles, FSM back in IDLE; macro off -> stays BUSY.
